width_downsizer: RTL and testbench



---
 rtl/dw_adapter_pkg.sv | 24 ++
 rtl/width_downsizer_if.sv | 44 ++++
 rtl/lane_counter.sv | 45 ++++
 rtl/width_downsizer.sv | 130 +++++++++++++
 tb/tb_width_downsizer.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/dw_adapter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dw_adapter_pkg
// Description : Shared types and helpers for the width downsizer.
//               dw_state_t - IDLE (no word held) / SHIFT (word being emitted)
//               cnt_width  - counter width able to hold 0..lanes
// Revision    : 1.0 - initial release
// ============================================================================
package dw_adapter_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } dw_state_t;

  // max(1, clog2(lanes+1)): the counter must represent both 0 and 'lanes'.
  function automatic int cnt_width(input int lanes);
    int w;
    w = $clog2(lanes + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/width_downsizer_if.sv
`default_nettype none
// ============================================================================
// Module      : width_downsizer_if
// Description : Handshake bundle of the width downsizer.
//               Upstream : parallel_valid_i / parallel_ready_o / parallel_i /
//                          lanes_i
//               Downstream: serial_valid_o / serial_ready_i / serial_o /
//                          serial_last_o
//               Misc     : clk_en_i (clock enable), busy_o
//               slave  modport - the downsizer itself
//               master modport - the environment driving the downsizer
// Revision    : 1.0 - initial release
// ============================================================================
interface width_downsizer_if #(
  parameter int WORD_WIDTH = 32,
  parameter int LANE_WIDTH = 8
);
  import dw_adapter_pkg::*;

  localparam int CNT_W = cnt_width(WORD_WIDTH / LANE_WIDTH);

  logic                  clk_en_i;
  logic                  parallel_valid_i;
  logic                  parallel_ready_o;
  logic [WORD_WIDTH-1:0] parallel_i;
  logic [CNT_W-1:0]      lanes_i;
  logic                  serial_valid_o;
  logic                  serial_ready_i;
  logic [LANE_WIDTH-1:0] serial_o;
  logic                  serial_last_o;
  logic                  busy_o;

  modport slave (
    input  clk_en_i, parallel_valid_i, parallel_i, lanes_i, serial_ready_i,
    output parallel_ready_o, serial_valid_o, serial_o, serial_last_o, busy_o
  );

  modport master (
    output clk_en_i, parallel_valid_i, parallel_i, lanes_i, serial_ready_i,
    input  parallel_ready_o, serial_valid_o, serial_o, serial_last_o, busy_o
  );

endinterface
`default_nettype wire

// File: rtl/lane_counter.sv
`default_nettype none
// ============================================================================
// Module      : lane_counter
// Description : Remaining-lane counter. Load has priority over decrement;
//               decrement saturates at zero.
//               clk, rst       - clock, asynchronous active-high reset
//               i_en           - clock enable
//               i_load         - load i_load_value
//               i_dec          - decrement by one
//               o_count        - current count
//               o_zero         - count is zero
// Revision    : 1.0 - initial release
// ============================================================================
module lane_counter #(
  parameter int CNT_W = 3
) (
  input  wire              clk,
  input  wire              rst,
  input  wire              i_en,
  input  wire              i_load,
  input  wire  [CNT_W-1:0] i_load_value,
  input  wire              i_dec,
  output logic [CNT_W-1:0] o_count,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_en) begin
      if (i_load) begin
        r_count <= i_load_value;
      end else if (i_dec && (r_count != '0)) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  assign o_count = r_count;
  assign o_zero  = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/width_downsizer.sv
`default_nettype none
// ============================================================================
// Module      : width_downsizer
// Description : Serialises a WORD_WIDTH parallel word into LANE_WIDTH beats
//               with valid/ready handshakes on both sides. A new word can be
//               accepted in the same cycle the final lane of the previous one
//               is taken, so back-to-back words stream without a bubble.
//               clk_i  - clock (rising edge)
//               rst_i  - asynchronous active-high reset
//               bus    - width_downsizer_if.slave (handshakes, data, busy_o)
// Revision    : 1.0 - initial release
// ============================================================================
module width_downsizer
  import dw_adapter_pkg::*;
#(
  parameter int WORD_WIDTH = 32,
  parameter int LANE_WIDTH = 8,
  parameter int MSB_FIRST  = 0
) (
  input  wire               clk_i,
  input  wire               rst_i,
  width_downsizer_if.slave  bus
);

  localparam int c_lanes = WORD_WIDTH / LANE_WIDTH;
  localparam int c_cnt_w = cnt_width(c_lanes);

  if ((WORD_WIDTH % LANE_WIDTH) != 0) begin : g_bad_ratio
    $error("width_downsizer: WORD_WIDTH must be a multiple of LANE_WIDTH");
  end

  dw_state_t             r_state;
  dw_state_t             w_state_next;
  logic [WORD_WIDTH-1:0] r_shift;
  logic [WORD_WIDTH-1:0] w_shifted;
  logic [LANE_WIDTH-1:0] w_lane;
  logic [c_cnt_w-1:0]    w_count;
  logic [c_cnt_w-1:0]    w_lanes_eff;
  logic                  w_zero;
  logic                  w_valid;
  logic                  w_last;
  logic                  w_dn;
  logic                  w_ready;
  logic                  w_up;

  // 0 or an out-of-range request means "the whole word".
  assign w_lanes_eff = ((bus.lanes_i == '0) || (bus.lanes_i > c_cnt_w'(c_lanes)))
                       ? c_cnt_w'(c_lanes) : bus.lanes_i;

  assign w_up = bus.parallel_valid_i && w_ready;

  lane_counter #(
    .CNT_W (c_cnt_w)
  ) u_lane_counter (
    .clk          (clk_i),
    .rst          (rst_i),
    .i_en         (bus.clk_en_i),
    .i_load       (w_up),
    .i_load_value (w_lanes_eff),
    .i_dec        (w_dn),
    .o_count      (w_count),
    .o_zero       (w_zero)
  );

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else if (bus.clk_en_i) begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_up) w_state_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        // A concurrent load keeps us in SHIFT; an empty counter while
        // shifting can only follow a corrupted state and is recovered here.
        if (w_up) begin
          w_state_next = ST_SHIFT;
        end else if ((w_dn && w_last) || w_zero) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Output / handshake logic
  always_comb begin
    w_valid = (r_state == ST_SHIFT);
    w_last  = w_valid && (w_count == c_cnt_w'(1));
    w_dn    = w_valid && bus.serial_ready_i && bus.clk_en_i;
    w_ready = bus.clk_en_i && (!w_valid || (w_dn && w_last));
  end

  // The output lane sits at one end of the register; shifting toward it with
  // zero fill brings the next lane into place. With MSB-first and a short
  // word, the top lanes are the ones emitted.
  if (MSB_FIRST != 0) begin : g_msb_first
    assign w_lane    = r_shift[WORD_WIDTH-1 -: LANE_WIDTH];
    assign w_shifted = r_shift << LANE_WIDTH;
  end else begin : g_lsb_first
    assign w_lane    = r_shift[LANE_WIDTH-1:0];
    assign w_shifted = r_shift >> LANE_WIDTH;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_shift <= '0;
    end else if (w_up) begin
      r_shift <= bus.parallel_i;
    end else if (w_dn) begin
      r_shift <= w_shifted;
    end
  end

  assign bus.parallel_ready_o = w_ready;
  assign bus.serial_valid_o   = w_valid;
  assign bus.busy_o           = w_valid;
  assign bus.serial_last_o    = w_last;
  assign bus.serial_o         = w_lane;

endmodule
`default_nettype wire

// File: tb/tb_width_downsizer.sv
`default_nettype none
// ============================================================================
// Module      : tb_width_downsizer
// Description : Self-checking bench. Two instances (LSB-first and MSB-first)
//               share one stimulus; a queue of expected lanes per instance
//               predicts every output each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_width_downsizer;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        pv;
  logic        sready;
  logic [31:0] pword;
  logic [2:0]  plane;

  always #5 clk = ~clk;

  width_downsizer_if #(.WORD_WIDTH(32), .LANE_WIDTH(8)) bus_l ();
  width_downsizer_if #(.WORD_WIDTH(32), .LANE_WIDTH(8)) bus_m ();

  assign bus_l.clk_en_i         = en;
  assign bus_l.parallel_valid_i = pv;
  assign bus_l.parallel_i       = pword;
  assign bus_l.lanes_i          = plane;
  assign bus_l.serial_ready_i   = sready;
  assign bus_m.clk_en_i         = en;
  assign bus_m.parallel_valid_i = pv;
  assign bus_m.parallel_i       = pword;
  assign bus_m.lanes_i          = plane;
  assign bus_m.serial_ready_i   = sready;

  width_downsizer #(.WORD_WIDTH(32), .LANE_WIDTH(8), .MSB_FIRST(0)) dut_lsb (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_l)
  );

  width_downsizer #(.WORD_WIDTH(32), .LANE_WIDTH(8), .MSB_FIRST(1)) dut_msb (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_m)
  );

  int         errors = 0;
  int         checks = 0;
  logic [7:0] q_l[$];
  logic [7:0] q_m[$];
  bit         last_up = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: a word yields n lanes, lowest byte first or highest byte first.
  task automatic push_word(input logic [31:0] w, input logic [2:0] l);
    int n;
    n = ((l == 3'd0) || (l > 3'd4)) ? 4 : int'(l);
    for (int i = 0; i < n; i++) begin
      q_l.push_back(w[8*i +: 8]);
      q_m.push_back(w[8*(3-i) +: 8]);
    end
  endtask

  task automatic check_outputs(input string nm, input logic rdy, input logic vld,
                               input logic bsy, input logic lst, input logic [7:0] ser,
                               input int qsize, input logic [7:0] qhead, input logic exp_rdy);
    chk({nm, "_ready"}, 32'(rdy), 32'(exp_rdy));
    chk({nm, "_valid"}, 32'(vld), 32'(qsize != 0));
    chk({nm, "_busy"},  32'(bsy), 32'(qsize != 0));
    chk({nm, "_last"},  32'(lst), 32'(qsize == 1));
    if (qsize != 0) chk({nm, "_serial"}, 32'(ser), 32'(qhead));
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_lsb_valid"},  32'(bus_l.serial_valid_o), 32'd0);
    chk({nm, "_lsb_last"},   32'(bus_l.serial_last_o),  32'd0);
    chk({nm, "_lsb_busy"},   32'(bus_l.busy_o),         32'd0);
    chk({nm, "_lsb_serial"}, 32'(bus_l.serial_o),       32'd0);
    chk({nm, "_msb_valid"},  32'(bus_m.serial_valid_o), 32'd0);
    chk({nm, "_msb_last"},   32'(bus_m.serial_last_o),  32'd0);
    chk({nm, "_msb_busy"},   32'(bus_m.busy_o),         32'd0);
    chk({nm, "_msb_serial"}, 32'(bus_m.serial_o),       32'd0);
    chk({nm, "_lsb_ready"},  32'(bus_l.parallel_ready_o), 32'(en));
  endtask

  // One clock: inputs are set beforehand (posedge+1), checked at negedge,
  // reference updated at the next posedge.
  task automatic cycle();
    bit exp_rdy;
    bit up;
    bit dn;
    @(negedge clk);
    exp_rdy = en && ((q_l.size() == 0) || ((q_l.size() == 1) && sready));
    check_outputs("lsb", bus_l.parallel_ready_o, bus_l.serial_valid_o, bus_l.busy_o,
                  bus_l.serial_last_o, bus_l.serial_o, q_l.size(),
                  (q_l.size() != 0) ? q_l[0] : 8'h00, exp_rdy);
    check_outputs("msb", bus_m.parallel_ready_o, bus_m.serial_valid_o, bus_m.busy_o,
                  bus_m.serial_last_o, bus_m.serial_o, q_m.size(),
                  (q_m.size() != 0) ? q_m[0] : 8'h00, exp_rdy);
    up = pv && exp_rdy;
    dn = en && sready && (q_l.size() != 0);
    @(posedge clk);
    if (dn) begin
      void'(q_l.pop_front());
      void'(q_m.pop_front());
    end
    if (up) push_word(pword, plane);
    last_up = up;
    #1;
  endtask

  task automatic offer(input logic [31:0] w, input logic [2:0] l);
    int k;
    k = 0;
    pv = 1'b1; pword = w; plane = l;
    do begin
      cycle();
      k++;
    end while (!last_up && (k < 64));
    pv = 1'b0;
    chk("accept_timeout", 32'(last_up), 32'd1);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((q_l.size() != 0) && (k < 64)) begin
      cycle();
      k++;
    end
    chk("drain_timeout", 32'(q_l.size()), 32'd0);
    cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b1; pv = 1'b0; sready = 1'b1; pword = '0; plane = '0;
    #1 check_zero("por");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Full word, lanes 0 -> 4 lanes
    offer(32'hA1B2C3D4, 3'd0);
    drain();
    // Two lanes: D4,C3 / A1,B2
    offer(32'hA1B2C3D4, 3'd2);
    drain();
    // Out-of-range lane count clamps to the full word
    offer(32'h11223344, 3'd7);
    drain();
    offer(32'h55667788, 3'd1);
    drain();

    // Backpressure then clock-enable freeze while C3 is presented
    offer(32'hA1B2C3D4, 3'd0);
    cycle();
    sready = 1'b0;
    repeat (3) cycle();
    sready = 1'b1;
    en = 1'b0;
    repeat (2) cycle();
    en = 1'b1;
    drain();

    // Back-to-back words stream without a bubble
    offer(32'h03020100, 3'd0);
    offer(32'h07060504, 3'd0);
    drain();

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      pv     = 1'($urandom_range(0, 1));
      pword  = $urandom;
      plane  = 3'($urandom_range(0, 7));
      sready = ($urandom_range(0, 3) != 0);
      en     = ($urandom_range(0, 7) != 0);
      cycle();
    end
    pv = 1'b0; en = 1'b1; sready = 1'b1;
    drain();

    // Reset mid-word after two lanes
    offer(32'hA1B2C3D4, 3'd0);
    cycle();
    cycle();
    #2 rst = 1'b1;
    #1 check_zero("midrst");
    q_l.delete();
    q_m.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    cycle();
    offer(32'hCAFEF00D, 3'd0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
